lif_scheduler: RTL and testbench

//  Time-multiplexes one leaky-integrate-and-fire update datapath across N neurons.

---
 rtl/lif_pkg.sv | 31 +++
 rtl/lif_update.sv | 26 ++
 rtl/lif_scheduler.sv | 157 +++++++++++++++
 tb/tb_lif_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types, reset constants and arithmetic helpers for the LIF neuron scheduler.
package lif_pkg;

    localparam int DEF_W         = 8;
    localparam int DEF_N_NEURONS = 8;
    localparam int BETA_W        = 4;
    localparam int BETA_FRAC     = 4;
    localparam int RST_THRESHOLD = 127;
    localparam int RST_BETA      = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EMIT,
        FIN
    } fsm_t;

    // Unsigned add clamped to the largest w-bit value; w must stay below 32.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step: decides firing and computes the next membrane value.
module lif_update
    import lif_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]      s,
    input  logic [W-1:0]      cur,
    input  logic [W-1:0]      threshold,
    input  logic [BETA_W-1:0] beta,
    output logic [W-1:0]      nxt,
    output logic              fire
);

    logic [W+BETA_W-1:0] w_prod;
    logic [W-1:0]        w_leak;
    logic [W-1:0]        w_leak_sel;

    // beta is Q0.4, so the retained leak is the product with its fraction bits dropped.
    assign w_prod     = (W+BETA_W)'(s) * (W+BETA_W)'(beta);
    assign w_leak     = W'(w_prod >> BETA_FRAC);
    assign fire       = (s >= threshold);
    assign w_leak_sel = fire ? '0 : w_leak;
    assign nxt        = W'(sat_add(32'(cur), 32'(w_leak_sel), W));

endmodule

// File: rtl/lif_scheduler.sv
// Walks N neurons per timestep through one shared LIF datapath, streaming currents in and spikes out.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int W         = DEF_W,
    parameter int IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [W-1:0]     cfg_data,
    input  logic [W-1:0]     cur_data,
    input  logic             cur_valid,
    output logic             cur_ready,
    output logic [IDX_W-1:0] cur_idx,
    output logic             spk_valid,
    input  logic             spk_ready,
    output logic [IDX_W-1:0] spk_id,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tstep
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    fsm_t              r_fsm;
    fsm_t              w_fsm_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  r_spk_id;
    logic [W-1:0]      r_threshold;
    logic [BETA_W-1:0] r_beta;
    logic [15:0]       r_tstep;
    logic [W-1:0]      r_state [N_NEURONS];

    logic [W-1:0]      w_s;
    logic [W-1:0]      w_nxt;
    logic              w_fire;
    logic              w_cur_hs;
    logic              w_cfg_wr;

    assign w_s      = r_state[r_idx];
    assign w_cur_hs = (r_fsm == FETCH) && cur_valid;
    assign w_cfg_wr = (r_fsm == IDLE) && cfg_we;

    lif_update #(
        .W(W)
    ) u_update (
        .s         (w_s),
        .cur       (cur_data),
        .threshold (r_threshold),
        .beta      (r_beta),
        .nxt       (w_nxt),
        .fire      (w_fire)
    );

    // NOTE: every output of this block is assigned a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_idx_nxt = r_idx;
        cur_ready = 1'b0;
        spk_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (r_fsm)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_fsm_nxt = FETCH;
                    w_idx_nxt = '0;
                end
            end
            FETCH: begin
                cur_ready = 1'b1;
                if (cur_valid) begin
                    if (w_fire) begin
                        w_fsm_nxt = EMIT;
                    end else if (r_idx == LAST_IDX) begin
                        w_fsm_nxt = FIN;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            EMIT: begin
                spk_valid = 1'b1;
                if (spk_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_fsm_nxt = FIN;
                    end else begin
                        w_fsm_nxt = FETCH;
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            FIN: begin
                done      = 1'b1;
                w_fsm_nxt = IDLE;
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm    <= IDLE;
            r_idx    <= '0;
            r_spk_id <= '0;
            r_tstep  <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_idx <= w_idx_nxt;
            if (w_cur_hs && w_fire) begin
                r_spk_id <= r_idx;
            end
            if (r_fsm == FIN) begin
                r_tstep <= r_tstep + 16'd1;
            end
        end
    end

    // Config is only writable between timesteps, so a running timestep never sees it change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_threshold <= W'(RST_THRESHOLD);
            r_beta      <= BETA_W'(RST_BETA);
        end else if (w_cfg_wr) begin
            if (cfg_sel) begin
                r_beta <= cfg_data[BETA_W-1:0];
            end else begin
                r_threshold <= cfg_data;
            end
        end
    end

    // NOTE: the membrane file is reset entry by entry, so it maps to flops rather than a reset-less RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_state[i] <= '0;
            end
        end else if (w_cur_hs) begin
            r_state[r_idx] <= w_nxt;
        end
    end

    assign cur_idx = r_idx;
    assign spk_id  = r_spk_id;
    assign tstep   = r_tstep;

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: a reference model predicts spikes into a queue and membrane states.
module tb_lif_scheduler;

    localparam int N = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        cfg_we;
    logic        cfg_sel;
    logic [7:0]  cfg_data;
    logic [7:0]  cur_data;
    logic        cur_valid;
    logic        cur_ready;
    logic [2:0]  cur_idx;
    logic        spk_valid;
    logic        spk_ready;
    logic [2:0]  spk_id;
    logic        busy;
    logic        done;
    logic [15:0] tstep;

    int          n_checks;
    int          n_errors;
    int          exp_q [$];
    logic [7:0]  cur_tab [N];
    logic [7:0]  m_state [N];
    logic [7:0]  m_thr;
    logic [3:0]  m_beta;
    logic [15:0] m_tstep;

    lif_scheduler #(
        .N_NEURONS (N),
        .W         (8),
        .IDX_W     (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .cur_data  (cur_data),
        .cur_valid (cur_valid),
        .cur_ready (cur_ready),
        .cur_idx   (cur_idx),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_id    (spk_id),
        .busy      (busy),
        .done      (done),
        .tstep     (tstep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cur_data = cur_tab[cur_idx];
    endtask

    function automatic void lif_model(input logic [7:0] s, input logic [7:0] cur,
                                      output logic [7:0] nxt, output bit fire);
        int leak;
        int sum;
        fire = (s >= m_thr);
        leak = (int'(s) * int'(m_beta)) / 16;
        sum  = int'(cur) + (fire ? 0 : leak);
        nxt  = (sum > 255) ? 8'd255 : 8'(sum);
    endfunction

    // Spike scoreboard: every accepted spike must match the next predicted id.
    always @(negedge clk) begin
        if (!rst && spk_valid && spk_ready) begin
            if (exp_q.size() == 0) begin
                check("spk_unexpected", 32'(spk_id), 32'hFFFF_FFFF);
            end else begin
                check("spk_id", 32'(spk_id), exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_state[i] = 8'd0;
        m_thr   = 8'd127;
        m_beta  = 4'd8;
        m_tstep = 16'd0;
        exp_q.delete();
    endtask

    task automatic check_states(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_state%0d", tag, i), 32'(dut.r_state[i]), 32'(m_state[i]));
        end
    endtask

    task automatic set_cur_all(input logic [7:0] v);
        for (int i = 0; i < N; i++) cur_tab[i] = v;
        cur_data = cur_tab[cur_idx];
    endtask

    task automatic cfg_write(input logic sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
        if (sel) m_beta = data[3:0];
        else     m_thr  = data;
        check("cfg_idle", 32'(busy), 32'd0);
    endtask

    // One full timestep: predict, run with optional backpressure/busy-time pokes, then verify.
    task automatic do_timestep(input string tag, input int hold, input bit inject,
                               input bit cfg_now, input logic cfg_sel_v, input logic [7:0] cfg_v);
        logic [7:0] prev [N];
        logic [7:0] nxt;
        bit         fire;
        bit         seen_spk;
        int         first_spk;
        int         ticks;

        if (cfg_now) begin
            if (cfg_sel_v) m_beta = cfg_v[3:0];
            else           m_thr  = cfg_v;
        end
        first_spk = -1;
        seen_spk  = 1'b0;
        for (int i = 0; i < N; i++) begin
            prev[i] = m_state[i];
            lif_model(m_state[i], cur_tab[i], nxt, fire);
            if (fire) begin
                exp_q.push_back(i);
                if (first_spk < 0) first_spk = i;
            end
            m_state[i] = nxt;
        end

        if (hold > 0) spk_ready = 1'b0;
        start = 1'b1;
        if (cfg_now) begin
            cfg_we   = 1'b1;
            cfg_sel  = cfg_sel_v;
            cfg_data = cfg_v;
        end
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        ticks  = 1;

        while (!done && ticks < 200) begin
            if (first_spk < 0) begin
                check($sformatf("%s_cur_idx", tag), 32'(cur_idx), 32'(ticks - 1));
            end
            if (inject) begin
                start    = (ticks == 3);
                cfg_we   = (ticks == 3);
                cfg_sel  = 1'b0;
                cfg_data = 8'd0;
            end
            if (hold > 0 && spk_valid && !seen_spk) begin
                seen_spk = 1'b1;
                repeat (hold) begin
                    check($sformatf("%s_bp_valid", tag), 32'(spk_valid), 32'd1);
                    check($sformatf("%s_bp_id", tag), 32'(spk_id), 32'(first_spk));
                    check($sformatf("%s_bp_cur_ready", tag), 32'(cur_ready), 32'd0);
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("%s_bp_state%0d", tag, i), 32'(dut.r_state[i]),
                              32'((i <= first_spk) ? m_state[i] : prev[i]));
                    end
                    tick();
                    ticks++;
                end
                spk_ready = 1'b1;
            end else begin
                tick();
                ticks++;
            end
        end
        start  = 1'b0;
        cfg_we = 1'b0;

        check($sformatf("%s_done", tag), 32'(done), 32'd1);
        if (first_spk < 0) check($sformatf("%s_latency", tag), 32'(ticks), 32'(N + 1));
        if (hold > 0) check($sformatf("%s_bp_seen", tag), 32'(seen_spk), 32'd1);
        m_tstep = m_tstep + 16'd1;
        tick();
        check($sformatf("%s_done_pulse", tag), 32'(done), 32'd0);
        check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
        check($sformatf("%s_tstep", tag), 32'(tstep), 32'(m_tstep));
        check($sformatf("%s_spk_left", tag), 32'(exp_q.size()), 32'd0);
        check_states(tag);
        if (inject) begin
            tick();
            check($sformatf("%s_start_not_queued", tag), 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_data  = 8'd0;
        cur_data  = 8'd0;
        cur_valid = 1'b1;
        spk_ready = 1'b1;
        for (int i = 0; i < N; i++) cur_tab[i] = 8'd0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ready", 32'(cur_ready), 32'd0);
        check("rst_spk_valid", 32'(spk_valid), 32'd0);
        check("rst_cur_idx", 32'(cur_idx), 32'd0);
        check("rst_spk_id", 32'(spk_id), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tstep", 32'(tstep), 32'd0);
        check_states("rst");

        // Constant current 100: 100 -> 150 -> 100, spikes only in the third timestep
        set_cur_all(8'd100);
        do_timestep("ts1", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        do_timestep("ts2", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        do_timestep("ts3", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        check("ts3_tstep_is_3", 32'(tstep), 32'd3);

        // Backpressure on a single spike from neuron 3
        set_cur_all(8'd0);
        cur_tab[3] = 8'd200;
        do_timestep("ts4", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        set_cur_all(8'd0);
        do_timestep("bp", 5, 1'b0, 1'b0, 1'b0, 8'd0);

        // Reset while a spike is stalled in EMIT
        cfg_write(1'b0, 8'd0);
        spk_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && !spk_valid; k++) tick();
        check("abort_in_emit", 32'(spk_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_spk_valid", 32'(spk_valid), 32'd0);
        check("abort_cur_ready", 32'(cur_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_tstep", 32'(tstep), 32'd0);
        check("abort_cur_idx", 32'(cur_idx), 32'd0);
        model_reset();
        check_states("abort");
        rst = 1'b0;
        spk_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end

        // Threshold 50: state 50 fires, 49 does not; busy-time start/config ignored
        set_cur_all(8'd0);
        cur_tab[0] = 8'd50;
        cur_tab[1] = 8'd49;
        cur_data   = cur_tab[cur_idx];
        do_timestep("thr_setup", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        cfg_write(1'b0, 8'd50);
        set_cur_all(8'd0);
        do_timestep("thr50", 0, 1'b1, 1'b0, 1'b0, 8'd0);

        // beta=15 written together with start, then saturation at 255 and firing next step
        set_cur_all(8'd200);
        do_timestep("beta_start", 0, 1'b0, 1'b1, 1'b1, 8'd15);
        cfg_write(1'b0, 8'd255);
        set_cur_all(8'd255);
        do_timestep("sat", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        set_cur_all(8'd10);
        do_timestep("sat_fire", 0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
